// File: rtl/caravel_ram_wb_ctrl.sv
// caravel_ram_wb_ctrl
// Wishbone classic slave in front of the 6Kx32 single-port RAM macro.
// Each bus cycle becomes one registered RAM command. Read data and ack are
// returned to the bus, and out-of-range word indices are answered with err.
// Optional feature macro: RAM_CLEAR_EN. When it is defined, every word is
// zeroed after reset and init_done stays low until the sweep completes.
//
// state | meaning
// IDLE  | waiting for cyc & stb; request decoded here only
// CMD   | RAM command on ram_*; RAM samples it at the end of this cycle
// DATA  | read data on ram_do; captured into wb_dat_o
// ACK   | wb_ack_o high for this one cycle
// ERR   | wb_err_o high for this one cycle (index >= DEPTH)
// CLEAR | post-reset zero sweep (RAM_CLEAR_EN only)
module caravel_ram_wb_ctrl #(
  parameter int DEPTH = 6144,
  parameter int AW    = 13
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [31:0]   wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_a,
  output logic [31:0]   ram_di,
  input  logic [31:0]   ram_do,
  output logic          init_done
);

`ifdef RAM_CLEAR_EN
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_ACK, S_ERR, S_CLEAR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_ACK, S_ERR} state_t;
`endif

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  state_t        r_state;
  logic          r_we_op;
  logic          r_ram_en;
  logic [3:0]    r_ram_we;
  logic [AW-1:0] r_ram_a;
  logic [31:0]   r_ram_di;
  logic [31:0]   r_dat;
  logic          r_ack;
  logic          r_err;

  logic          w_req;
  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_unused;

  assign w_req      = wb_cyc_i & wb_stb_i;
  assign w_idx      = wb_adr_i[AW+1:2];
  assign w_in_range = ({1'b0, w_idx} < LP_DEPTH);
  // Upper address bits are decoded upstream and the byte offset is irrelevant
  // for word accesses.
  assign w_unused   = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign ram_en   = r_ram_en;
  assign ram_we   = r_ram_we;
  assign ram_a    = r_ram_a;
  assign ram_di   = r_ram_di;

`ifdef RAM_CLEAR_EN
  logic r_init_done;
  assign init_done = r_init_done;

  // init_done rises once when the clear sweep leaves CLEAR.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_init_done <= 1'b0;
    end else if (r_state == S_CLEAR && r_ram_en && r_ram_a == AW'(DEPTH-1)) begin
      r_init_done <= 1'b1;
    end
  end
`else
  assign init_done = 1'b1;
`endif

  // Bus/RAM sequencing FSM; all bus- and RAM-side outputs are registered here.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
`ifdef RAM_CLEAR_EN
      r_state  <= S_CLEAR;
`else
      r_state  <= S_IDLE;
`endif
      r_we_op  <= 1'b0;
      r_ram_en <= 1'b0;
      r_ram_we <= 4'h0;
      r_ram_a  <= '0;
      r_ram_di <= '0;
      r_dat    <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_in_range) begin
              r_ram_en <= 1'b1;
              r_ram_we <= wb_we_i ? wb_sel_i : 4'h0;
              r_ram_a  <= w_idx;
              r_ram_di <= wb_dat_i;
              r_we_op  <= wb_we_i;
              r_state  <= S_CMD;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end
          end
        end
        S_CMD: begin
          // The access always completes; a dropped cycle only suppresses ack.
          r_ram_en <= 1'b0;
          r_ram_we <= 4'h0;
          if (!r_we_op) begin
            r_state <= S_DATA;
          end else if (wb_cyc_i) begin
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          r_dat <= ram_do;
          if (wb_cyc_i) begin
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ACK: r_state <= S_IDLE;
        S_ERR: r_state <= S_IDLE;
`ifdef RAM_CLEAR_EN
        S_CLEAR: begin
          // ram_a doubles as the sweep address: first cycle arms word 0.
          if (!r_ram_en) begin
            r_ram_en <= 1'b1;
            r_ram_we <= 4'hF;
            r_ram_a  <= '0;
            r_ram_di <= '0;
          end else if (r_ram_a == AW'(DEPTH-1)) begin
            r_ram_en <= 1'b0;
            r_ram_we <= 4'h0;
            r_state  <= S_IDLE;
          end else begin
            r_ram_a <= r_ram_a + 1'b1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_caravel_ram_wb_ctrl.sv
// Testbench for caravel_ram_wb_ctrl: directed cases followed by randomized
// transfers. Expectations are queued at issue time and checked by a monitor
// whenever the DUT pulses ack or err.
module tb_caravel_ram_wb_ctrl;
  localparam int DEPTH = 6144;
  localparam int AW    = 13;

  logic          CLK = 1'b0;
  logic          RESETn;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]    wb_sel_i;
  logic [31:0]   wb_adr_i, wb_dat_i, wb_dat_o;
  logic          wb_ack_o, wb_err_o;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_a;
  logic [31:0]   ram_di;
  logic [31:0]   ram_do = '0;
  logic          init_done;

  always #5 CLK = ~CLK;

  caravel_ram_wb_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
    .ram_do(ram_do), .init_done(init_done)
  );

  // Behavioural RAM macro attached to the DUT (environment, not the model).
  logic [31:0] ram_mem [0:(1<<AW)-1];
  logic [31:0] ram_tmp;
  always @(posedge CLK) begin
    if (ram_en) begin
      ram_tmp = ram_mem[ram_a];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_tmp[8*b +: 8] = ram_di[8*b +: 8];
      ram_do <= ram_mem[ram_a];
      ram_mem[ram_a] <= ram_tmp;
    end
  end

  // Reference model: word array as the bus should see it, plus last read.
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] ref_last;

  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack/err pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (RESETn === 1'b1 && (wb_ack_o || wb_err_o)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_pulse: ack=%b err=%b, expected no pulse", wb_ack_o, wb_err_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", {30'b0, wb_err_o, wb_ack_o}, {30'b0, mon_e.is_err, ~mon_e.is_err});
        check("dat_o", wb_dat_o, mon_e.data);
        check("pulse_init_done", {31'b0, init_done}, 32'd1);
      end
    end
  end

  task automatic bus_idle();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_sel_i = 4'h0; wb_adr_i = '0;   wb_dat_i = '0;
  endtask

  function automatic logic [31:0] mk_adr(input int idx);
    return ($urandom & 32'hFFFF_8000) | (32'(idx) << 2) | ($urandom & 32'h3);
  endfunction

  task automatic wait_init();
`ifdef RAM_CLEAR_EN
    int cnt;
    cnt = 0;
    while (init_done !== 1'b1 && cnt < DEPTH + 50) begin
      @(negedge CLK);
      cnt++;
    end
    check("init_done_timeout", {31'b0, init_done}, 32'd1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
  endtask

  // One bus transfer. drop: 0 = normal, 1 = drop cyc in CMD, 2 = drop in DATA.
  task automatic xfer(input logic we, input logic [3:0] sel, input int idx,
                      input logic [31:0] dat, input int drop);
    logic        in_rng;
    logic [31:0] w;
    int          lat, exp_lat;
    in_rng = (idx < DEPTH);
    if (in_rng) begin
      if (we) begin
        w = ref_mem[idx];
        for (int b = 0; b < 4; b++)
          if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
        ref_mem[idx] = w;
      end else begin
        ref_last = ref_mem[idx];
      end
    end
    if (drop == 0) exp_q.push_back('{is_err: ~in_rng, data: ref_last});

    @(negedge CLK);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_sel_i = sel;  wb_adr_i = mk_adr(idx); wb_dat_i = dat;
    @(negedge CLK);
    if (in_rng) begin
      check("cmd_en", {31'b0, ram_en}, 32'd1);
      check("cmd_a", 32'(ram_a), 32'(idx));
      check("cmd_we", {28'b0, ram_we}, {28'b0, (we ? sel : 4'h0)});
      if (we) check("cmd_di", ram_di, dat);
    end else begin
      check("err_no_en", {31'b0, ram_en}, 32'd0);
    end

    if (drop != 0) begin
      if (drop == 2) @(negedge CLK);
      bus_idle();
      repeat (3) @(negedge CLK);
      check("abort_en_clear", {31'b0, ram_en}, 32'd0);
    end else begin
      exp_lat = !in_rng ? 1 : (we ? 2 : 3);
      lat = 1;
      while (!(wb_ack_o || wb_err_o) && lat < 8) begin
        @(negedge CLK);
        lat++;
        if (!in_rng && ram_en) check("err_no_en_late", {31'b0, ram_en}, 32'd0);
      end
      check("latency", 32'(lat), 32'(exp_lat));
      bus_idle();
    end
  endtask

  int pool [8] = '{0, 1, 2, 3, DEPTH-1, DEPTH-2, 100, 2047};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int idx, drop, cnt;
    logic we;
    bus_idle();
    ref_last = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int i = 0; i < (1 << AW); i++) begin
`ifdef RAM_CLEAR_EN
      ram_mem[i] = $urandom;
`else
      ram_mem[i] = '0;
`endif
    end

    RESETn = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    check("rst_err", {31'b0, wb_err_o}, 32'd0);
    check("rst_en", {31'b0, ram_en}, 32'd0);
    check("rst_we", {28'b0, ram_we}, 32'd0);
    check("rst_a", 32'(ram_a), 32'd0);
    check("rst_di", ram_di, 32'd0);
    check("rst_dat_o", wb_dat_o, 32'd0);
`ifdef RAM_CLEAR_EN
    check("rst_init_done", {31'b0, init_done}, 32'd0);
`else
    check("rst_init_done", {31'b0, init_done}, 32'd1);
`endif
    RESETn = 1'b1;

`ifdef RAM_CLEAR_EN
    // Read raised at cycle 10 of the clear sweep must stall until clear ends.
    cnt = 0;
    while (init_done !== 1'b1 && cnt < DEPTH + 50) begin
      @(negedge CLK);
      cnt++;
      if (cnt == 10) begin
        exp_q.push_back('{is_err: 1'b0, data: 32'h0});
        ref_last = '0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_sel_i = 4'hF; wb_adr_i = mk_adr(1234);
      end
    end
    n_vec++;
    if (cnt < DEPTH || cnt > DEPTH + 2) begin
      n_miss++;
      $display("FAIL clear_length: got %0d cycles, expected %0d..%0d", cnt, DEPTH, DEPTH + 2);
    end
    cnt = 0;
    while (!wb_ack_o && cnt < 8) begin
      @(negedge CLK);
      cnt++;
    end
    check("clear_stall_ack", {31'b0, wb_ack_o}, 32'd1);
    bus_idle();
`endif

    // Full-word write then read back.
    xfer(1'b1, 4'hF, 16, 32'hDEADBEEF, 0);
    xfer(1'b0, 4'hF, 16, 32'h0, 0);
    // Single byte-lane write merges into the existing word.
    xfer(1'b1, 4'hF, 32, 32'h11223344, 0);
    xfer(1'b1, 4'b0100, 32, 32'h00AA0000, 0);
    xfer(1'b0, 4'hF, 32, 32'h0, 0);
    // Zero byte-enable write still completes and leaves the word untouched.
    xfer(1'b1, 4'h0, 32, 32'hFFFFFFFF, 0);
    xfer(1'b0, 4'hF, 32, 32'h0, 0);
    // First out-of-range index and the last one the address field can encode.
    xfer(1'b0, 4'hF, DEPTH, 32'h0, 0);
    xfer(1'b1, 4'hF, (1 << AW) - 1, 32'h12345678, 0);
    xfer(1'b0, 4'hF, DEPTH - 1, 32'h0, 0);
    // Read aborted in DATA, then a normal read of the same word.
    xfer(1'b1, 4'hF, 0, 32'hCAFEF00D, 0);
    xfer(1'b0, 4'hF, 0, 32'h0, 2);
    xfer(1'b0, 4'hF, 0, 32'h0, 0);
    // Write aborted in CMD still lands in the RAM.
    xfer(1'b1, 4'hF, 3, 32'h5A5A0F0F, 1);
    xfer(1'b0, 4'hF, 3, 32'h0, 0);

    // Reset while the RAM command is on the pins.
    @(negedge CLK);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_sel_i = 4'hF; wb_adr_i = mk_adr(16);
    @(negedge CLK);
    check("rst_mid_pre_en", {31'b0, ram_en}, 32'd1);
    #1 RESETn = 1'b0;
    #1;
    check("rst_mid_en", {31'b0, ram_en}, 32'd0);
    check("rst_mid_we", {28'b0, ram_we}, 32'd0);
    bus_idle();
    ref_last = '0;
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (4) @(negedge CLK);
    wait_init();
    xfer(1'b0, 4'hF, 16, 32'h0, 0);

    // Randomized traffic with back-to-back and gapped transfers.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) < 85) idx = pool[$urandom_range(0, 7)];
      else                            idx = $urandom_range(DEPTH, (1 << AW) - 1);
      we = 1'($urandom_range(0, 1));
      drop = 0;
      if (idx < DEPTH && $urandom_range(0, 9) == 0) drop = we ? 1 : $urandom_range(1, 2);
      xfer(we, 4'($urandom), idx, $urandom, drop);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    repeat (4) @(negedge CLK);
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
